// File: rtl/uart_rx_buffer_if.sv
// Bus-side signal bundle for the UART receive buffer: byte strobe from the deserializer,
// CPU request/response, and interrupt.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface uart_rx_buffer_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) ();
    logic                  rx_dv;
    logic [7:0]            rx_byte;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wrt_data;
    logic                  we;
    logic                  req_valid;
    logic                  sel;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  data_valid;
    logic                  irq;

    modport master (
        output rx_dv, rx_byte, addr, wrt_data, we, req_valid, sel,
        input  rd_data, data_valid, irq
    );

    modport slave (
        input  rx_dv, rx_byte, addr, wrt_data, we, req_valid, sel,
        output rd_data, data_valid, irq
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART RX byte FIFO with RXDATA/STATUS/CTRL registers; threshold irq under UART_RX_IRQ_EN.
// Latency: read response one cycle after the request; push/pop take effect at their edge.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flags overrun.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module uart_rx_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_rx_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OFF_RXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_NONE   = 2'd3;

    logic [7:0]            r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovr;
    logic                  r_rx_en;
    logic                  r_data_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_acc;
    logic [1:0]            w_off;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_req;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_ovr_set;
    logic                  w_ovr_clr;
    logic                  w_ctrl_wr;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_acc      = bus.sel & bus.req_valid;
    assign w_off      = bus.addr[3:2];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_rd_req   = w_acc & ~bus.we & (w_off != OFF_NONE);
    assign w_pop      = w_acc & ~bus.we & (w_off == OFF_RXDATA) & ~w_empty;
    assign w_push_req = bus.rx_dv & r_rx_en;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept the byte.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovr_set  = w_push_req & w_full & ~w_pop;
    assign w_ovr_clr  = w_acc & bus.we & (w_off == OFF_STATUS) & bus.wrt_data[2];
    assign w_ctrl_wr  = w_acc & bus.we & (w_off == OFF_CTRL);

`ifdef UART_RX_IRQ_EN
    logic [7:0] r_thresh;
    logic [7:0] w_thr_eff;
    logic       w_irq_lvl;
    logic       r_irq;

    assign w_thr_eff = (r_thresh < 8'd2) ? 8'd1 : r_thresh;
    assign w_irq_lvl = (9'(r_count) >= 9'(w_thr_eff)) | r_ovr;
    assign bus.irq   = r_irq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_thresh <= 8'd1;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_thresh <= bus.wrt_data[15:8];
            r_irq <= w_irq_lvl;
        end
    end
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        w_status         = '0;
        w_status[0]      = w_empty;
        w_status[1]      = w_full;
        w_status[2]      = r_ovr;
        w_status[8 +: CW] = r_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            OFF_RXDATA: if (!w_empty) w_rd_mux[7:0] = r_mem[r_rd_ptr];
            OFF_STATUS: w_rd_mux = w_status;
            OFF_CTRL: begin
                w_rd_mux[0] = r_rx_en;
`ifdef UART_RX_IRQ_EN
                w_rd_mux[15:8] = r_thresh;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ovr        <= 1'b0;
            r_rx_en      <= 1'b1;
            r_data_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovr_set)      r_ovr <= 1'b1;
            else if (w_ovr_clr) r_ovr <= 1'b0;
            if (w_ctrl_wr) r_rx_en <= bus.wrt_data[0];
            r_data_valid <= w_rd_req;
            r_rd_data    <= w_rd_req ? w_rd_mux : '0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.rx_byte;
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.data_valid = r_data_valid;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, bus.addr, bus.wrt_data};
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: read expectations queued at request time, checked on response.
module tb_uart_rx_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    uart_rx_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    uart_rx_buffer #(.DEPTH(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("spurious_data_valid", {31'b0, bus.data_valid}, 32'd0);
                else chk(tag_q.pop_front(), bus.rd_data, exp_q.pop_front());
            end else begin
                chk("rd_data_idle_zero", bus.rd_data, 32'd0);
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] b, input logic rq, input logic w,
                         input logic [1:0] off, input logic [31:0] wd, input logic [31:0] ex,
                         input string tag);
        @(posedge clk);
        #1;
        bus.rx_dv     = dv;
        bus.rx_byte   = b;
        bus.req_valid = rq;
        bus.sel       = rq;
        bus.we        = w;
        bus.addr      = {26'b0, off, 2'b00};
        bus.wrt_data  = wd;
        if (rq && !w && off != 2'd3) begin
            exp_q.push_back(ex);
            tag_q.push_back(tag);
        end
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, "");
    endtask
    task automatic push(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, "");
    endtask
    task automatic rd(input logic [1:0] off, input logic [31:0] ex, input string tag);
        drive(1'b0, 8'h00, 1'b1, 1'b0, off, 32'd0, ex, tag);
    endtask
    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        drive(1'b0, 8'h00, 1'b1, 1'b1, off, d, 32'd0, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_dv = 1'b0; bus.rx_byte = 8'h00; bus.req_valid = 1'b0; bus.sel = 1'b0;
        bus.we = 1'b0; bus.addr = '0; bus.wrt_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_irq", {31'b0, bus.irq}, 32'd0);
        chk("reset_data_valid", {31'b0, bus.data_valid}, 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        rst_n = 1'b1;

        // Reset state and basic FIFO order.
        rd(2'd1, 32'h0000_0001, "status_after_reset");
        idle();
        chk("irq_after_reset", {31'b0, bus.irq}, 32'd0);
        push(8'hA5);
        push(8'h3C);
        rd(2'd0, 32'h0000_00A5, "rxdata_first");
        rd(2'd0, 32'h0000_003C, "rxdata_second");
        rd(2'd1, 32'h0000_0001, "status_after_two_pops");
        rd(2'd0, 32'h0000_0000, "rxdata_empty");
        rd(2'd1, 32'h0000_0001, "status_empty_read_no_flags");
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 32'd0, 32'd0, "");
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd0, 32'h0000_00FF);
        rd(2'd1, 32'h0000_0001, "status_after_ignored_writes");

        // Overflow by one byte.
        for (int i = 0; i <= 16; i++) push(8'(i));
        rd(2'd1, 32'h0000_1006, "status_full_overrun");
        for (int i = 0; i < 16; i++) rd(2'd0, 32'(i), $sformatf("drain_overflow_%0d", i));
        rd(2'd1, 32'h0000_0005, "status_empty_overrun");
        wr(2'd1, 32'h0000_0004);
        rd(2'd1, 32'h0000_0001, "status_overrun_cleared");

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        drive(1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 32'd0, 32'h0000_0020, "full_push_pop_head");
        rd(2'd1, 32'h0000_1002, "status_full_no_overrun");
        for (int i = 1; i < 16; i++) rd(2'd0, 32'(8'h20 + i), $sformatf("drain_pushpop_%0d", i));
        rd(2'd0, 32'h0000_0055, "drain_pushpop_last");
        rd(2'd1, 32'h0000_0001, "status_after_pushpop_drain");

        // Overrun set beats a same-cycle clear.
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        drive(1'b1, 8'h77, 1'b1, 1'b1, 2'd1, 32'h0000_0004, 32'd0, "");
        rd(2'd1, 32'h0000_1006, "status_set_beats_clear");
        wr(2'd1, 32'h0000_0004);
        rd(2'd1, 32'h0000_1002, "status_clear_no_overflow");
        for (int i = 0; i < 16; i++) rd(2'd0, 32'(8'h40 + i), $sformatf("drain_setclr_%0d", i));
        rd(2'd1, 32'h0000_0001, "status_after_setclr_drain");

        // STATUS read in the same cycle as a push reports the pre-push count.
        drive(1'b1, 8'h99, 1'b1, 1'b0, 2'd1, 32'd0, 32'h0000_0001, "status_same_cycle_push");
        rd(2'd1, 32'h0000_0100, "status_after_push");
        rd(2'd0, 32'h0000_0099, "rxdata_after_push");

`ifdef UART_RX_IRQ_EN
        rd(2'd2, 32'h0000_0101, "ctrl_reset_value");
        wr(2'd2, 32'h0000_0301);
        rd(2'd2, 32'h0000_0301, "ctrl_readback");
        push(8'h61);
        push(8'h62);
        idle();
        idle();
        chk("irq_below_thresh", {31'b0, bus.irq}, 32'd0);
        push(8'h63);
        idle();
        idle();
        chk("irq_at_thresh", {31'b0, bus.irq}, 32'd1);
        rd(2'd0, 32'h0000_0061, "irq_pop");
        idle();
        idle();
        chk("irq_after_pop", {31'b0, bus.irq}, 32'd0);
        wr(2'd2, 32'h0000_0000);
        push(8'h64);
        rd(2'd1, 32'h0000_0200, "status_rx_disabled");
        wr(2'd2, 32'h0000_0101);
        rd(2'd0, 32'h0000_0062, "drain_irq_1");
        rd(2'd0, 32'h0000_0063, "drain_irq_2");
`else
        rd(2'd2, 32'h0000_0001, "ctrl_reset_value");
        wr(2'd2, 32'h0000_0301);
        rd(2'd2, 32'h0000_0001, "ctrl_thresh_ignored");
        push(8'h61);
        push(8'h62);
        push(8'h63);
        idle();
        idle();
        chk("irq_tied_low", {31'b0, bus.irq}, 32'd0);
        rd(2'd0, 32'h0000_0061, "drain_noirq_0");
        wr(2'd2, 32'h0000_0000);
        push(8'h64);
        rd(2'd1, 32'h0000_0200, "status_rx_disabled");
        wr(2'd2, 32'h0000_0001);
        rd(2'd0, 32'h0000_0062, "drain_noirq_1");
        rd(2'd0, 32'h0000_0063, "drain_noirq_2");
`endif
        rd(2'd1, 32'h0000_0001, "status_after_ctrl_tests");

        // Asynchronous reset mid-operation discards buffered bytes and restores CTRL.
        wr(2'd2, 32'h0000_0000);
        wr(2'd2, 32'h0000_0001);
        push(8'hB1);
        push(8'hB2);
        idle();
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_data_valid", {31'b0, bus.data_valid}, 32'd0);
        chk("midreset_irq", {31'b0, bus.irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(2'd1, 32'h0000_0001, "status_after_midreset");
`ifdef UART_RX_IRQ_EN
        rd(2'd2, 32'h0000_0101, "ctrl_after_midreset");
`else
        rd(2'd2, 32'h0000_0001, "ctrl_after_midreset");
`endif

        repeat (4) idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer for the memory-mapped UART. Sits directly downstream of the `Uart_rx` byte deserializer: captures each received byte into a byte FIFO, tracks overrun, and serves CPU system-bus reads/writes for RX data, status and control. It supplies the RX half of the UART address window, which the transmit path currently answers with zeros.

## Interface
- `DEPTH`, 16, FIFO entries in bytes; power of two, minimum 2.
- `ADDR_WIDTH`, `` `ADDR_WIDTH ``, system bus address width.
- `DATA_WIDTH`, `` `DATA_WIDTH ``, system bus data width; minimum 32.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_dv`  in  1  one-cycle strobe from `Uart_rx`: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `addr`  in  `ADDR_WIDTH`  bus address.
- `wrt_data`  in  `DATA_WIDTH`  bus write data.
- `we`  in  1  1 = write, 0 = read.
- `req_valid`  in  1  bus request strobe; one request per asserted cycle.
- `sel`  in  1  UART chip select, decoded upstream from `addr` top `IO_SELECT` bits.
- `rd_data`  out  `DATA_WIDTH`  read response data.
- `data_valid`  out  1  one-cycle response strobe for an accepted read.
- `irq`  out  1  level interrupt (see Configuration).

## Operation
- Register offset: `addr[3:2]`. The block responds only when `sel & req_valid` and `addr[3:2]` is 0, 1 or 2. Offset 3 is ignored: reads return 0, writes have no effect.
- Offset 0, RXDATA:
  - Read when not empty: returns `{24'b0, head byte}` and pops one entry.
  - Read when empty: returns 0 and sets no flags.
  - Writes are ignored.
- Offset 1, STATUS (read): bit0 empty, bit1 full, bit2 overrun, bits[7:3] reserved 0, bits[15:8] count, upper bits 0. Writing 1 to bit2 clears overrun; other write bits are ignored.
- Offset 2, CTRL (read/write):
  - bit0 `rx_en`: reset value 1. When 0, `rx_dv` is ignored.
  - bits[15:8] `thresh`: reset value 1. IRQ threshold; values 0 and 1 are both treated as 1.
- Push: happens on `rx_dv & rx_en`.
  - If not full, the byte is written at `wr_ptr`.
  - If full and no pop this cycle, the byte is dropped and overrun is set (sticky).
- Simultaneous push and pop: both are performed and count is unchanged, even when full. No overrun in that case.
- Pointers: `$clog2(DEPTH)` bits, wrap naturally. count is `$clog2(DEPTH)+1` bits, 0..DEPTH. empty = (count==0); full = (count==DEPTH).
- Simultaneous overrun-set and overrun-clear in the same cycle: set wins.
- Reset state:
  - Pointers and count are 0.
  - overrun is 0; `rx_en` is 1; `thresh` is 1.
  - `rd_data` is 0; `data_valid` is 0; `irq` is 0.
  - FIFO storage is not reset.
- Reset asserted mid-operation discards all buffered bytes immediately (asynchronous).

## Timing
- Read response is registered. Request in cycle N produces `rd_data` and `data_valid`=1 in cycle N+1.
- `data_valid` stays high for exactly one cycle.
- `rd_data` returns to 0 in the cycle after the response. `rd_data` is 0 whenever `data_valid`=0.
- Pop takes effect at the request edge. A STATUS read in cycle N+1 sees the decremented count.
- Push takes effect at the `rx_dv` edge. A STATUS read issued in the same cycle as `rx_dv` reports the pre-push count.
- Writes take effect at the request edge and produce no `data_valid`.
- Back-to-back reads, one per cycle, are supported. Each gets its own response one cycle later.
- `irq` is registered, so it lags the count change by one cycle.

## Configuration
- Macro: `UART_RX_IRQ_EN`.
- Defined: `irq` = (count >= effective `thresh`) | overrun, registered.
- Not defined:
  - `irq` is tied to 0.
  - CTRL bits[15:8] read as 0 and writes to them are ignored.
  - No threshold comparator is built.

## Test plan
- Reset, then read STATUS -> response one cycle later: `rd_data`=0x0000_0001 (empty), `data_valid` pulse of 1 cycle, `irq`=0.
- Push bytes 0xA5 then 0x3C, then read RXDATA twice -> 0x0000_00A5 then 0x0000_003C, then STATUS=0x0000_0001.
- Push 17 bytes 0x00..0x10 with DEPTH=16 -> STATUS=0x0000_1006 (count 16, full, overrun). Draining yields 0x00..0x0F; byte 0x10 is lost.
- With the FIFO full, apply `rx_dv`=0x55 and an RXDATA read in the same cycle -> read returns the oldest byte, count stays 16, overrun stays 0, 0x55 is the last byte drained.
- Write STATUS bit2=1 while `rx_dv` overflows the full FIFO in the same cycle -> overrun remains 1. A later clear write with no overflow -> overrun becomes 0.
- `UART_RX_IRQ_EN` defined: write CTRL=0x0000_0301 and push 2 bytes -> `irq`=0. Push a 3rd byte -> `irq`=1 one cycle later. Read one byte -> `irq`=0. Write CTRL=0 and push -> count unchanged.
